soundweb_tx_serializer: RTL and testbench
=========================================

Name: soundweb_tx_serializer

Overview:
- Downstream stage of soundweb_encoder.
- Captures the encoder's 29 parallel packet bytes (already framed: STX, escaped body, checksum, ETX) on a start pulse.
- Streams the bytes one per handshake over a valid/ready byte interface toward the UART transmitter.
- Stops after the ETX byte (0x03), so short packets do not transmit trailing padding.

Parameters:
- PACKET_BYTES, 29, number of packet byte slots accepted from the encoder.
- STX_BYTE, 8'h02, required first byte of a valid packet.
- ETX_BYTE, 8'h03, terminating byte; transmitted inclusive, then stop.
- GAP_CYCLES, 4, idle cycles between bytes (used only when SOUNDWEB_TX_GAP_EN is defined).

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to capture and send packet.
- packet  in  8*PACKET_BYTES  encoder packet_0..packet_28 concatenated; packet_0 at [7:0], packet_N at [8N+7:8N].
- tx_data  out  8  current byte.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  sink accepts byte when tx_valid & tx_ready.
- busy  out  1  high from the cycle after an accepted start until done/err.
- done  out  1  one-cycle pulse after the ETX byte is accepted.
- err  out  1  one-cycle pulse on framing fault.
- byte_count  out  5  bytes accepted by the sink in the current/last packet.

Behaviour:
- Reset (async, immediate): tx_valid=0, tx_data=0, busy=0, done=0, err=0, byte_count=0, state=IDLE, capture buffer cleared.
- States:
  - IDLE: on start, latch all bytes into the buffer, index=0, byte_count=0, go to CHECK.
  - CHECK: if buffer[0]!=STX_BYTE, pulse err and return to IDLE; else go to SEND.
  - SEND: tx_valid=1, tx_data=buffer[index].
  - GAP (feature only): idle countdown between bytes.
- Latency: start at cycle N gives tx_valid=1 with packet_0 at cycle N+2 (capture N, check N+1).
- Handshake rules:
  - Once tx_valid rises, tx_data and tx_valid hold until tx_valid&tx_ready.
  - tx_valid never depends combinationally on tx_ready.
- On accept in SEND:
  - byte_count increments.
  - If the accepted byte == ETX_BYTE: tx_valid=0 next cycle, done pulses next cycle, go to IDLE.
  - Else if index == PACKET_BYTES-1 (no ETX found): tx_valid=0, err pulses, go to IDLE.
  - Else index++, and the next byte is presented the following cycle with tx_valid held high (back-to-back, one byte per cycle at full ready).
- ETX match applies only to bytes at index>=1. The encoder escapes body 0x03, so the first unescaped 0x03 is the frame end.
- start while busy: ignored, and the buffer is not overwritten.
- start in the same cycle as done/err: ignored; a new start is accepted only in IDLE.
- byte_count holds its last value in IDLE until the next accepted start clears it. Maximum value is 29 (5 bits).
- Reset asserted mid-packet: tx_valid drops asynchronously and the partial packet is discarded, with no done or err.

Optional Feature:
- Macro: SOUNDWEB_TX_GAP_EN.
- Defined: after each accepted non-final byte, enter GAP with tx_valid=0 for exactly GAP_CYCLES cycles, then present the next byte. The counter is $clog2(GAP_CYCLES+1) bits. GAP_CYCLES=0 behaves as back-to-back.
- Not defined: no GAP state and no counter; bytes are back-to-back as above.

Decomposition:
- Package soundweb_pkg:
  - STX/ETX/ESC constants (8'h02, 8'h03, 8'h1B).
  - Packet length constant 29.
  - State enum (IDLE, CHECK, SEND, GAP).
- One natural sub-module: soundweb_gap_timer (loadable down-counter, done flag). Instantiated only under SOUNDWEB_TX_GAP_EN.

Test Plan:
- packet = 02 8D 1B 83 00 03, rest 00, tx_ready=1, start pulse:
  - exactly 6 bytes 02,8D,1B,83,00,03 on consecutive cycles;
  - done one cycle after 03 is accepted; byte_count=6; 00 padding never sent.
- Same packet, tx_ready toggling 1,0,0,1 repeating:
  - tx_data stable while tx_valid&!tx_ready;
  - no byte dropped or duplicated; byte_count=6.
- packet_0=8'h8D, start:
  - err pulses at cycle N+1; tx_valid never rises; busy returns 0.
- 29 bytes, 02 followed by twenty-eight 11, no 03:
  - 29 bytes sent, err pulses after the last; byte_count=29; no done.
- Second start pulse during SEND: ignored, and the output sequence is unchanged.
- reset at byte 3: tx_valid=0 immediately and all outputs at reset values. A fresh start then sends the full packet from byte 0.
- With SOUNDWEB_TX_GAP_EN, GAP_CYCLES=4: exactly 4 tx_valid=0 cycles between consecutive accepted bytes.

Source files
------------

// File: rtl/soundweb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : soundweb_pkg
// Description : Shared framing constants and the serializer state encoding
//               for the Soundweb transmit path.
// Revision    : 1.0 - initial release
// ============================================================================
package soundweb_pkg;

  // Framing bytes produced by the encoder
  localparam logic [7:0] SW_STX = 8'h02;
  localparam logic [7:0] SW_ETX = 8'h03;
  localparam logic [7:0] SW_ESC = 8'h1B;

  // Number of packet byte slots delivered by the encoder
  localparam int SW_PACKET_BYTES = 29;

  // Serializer states; GAP is only reachable when inter-byte gaps are built in
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_SEND  = 2'd2,
    ST_GAP   = 2'd3
  } sw_state_e;

endpackage
`default_nettype wire

// File: rtl/soundweb_gap_timer.sv
`default_nettype none
// ============================================================================
// Module      : soundweb_gap_timer
// Description : Loadable down-counter that reports expiry when the final idle
//               cycle of an inter-byte gap is in progress.
// Revision    : 1.0 - initial release
// ============================================================================
module soundweb_gap_timer #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] count_q;

  // Count down from the loaded value, parking at zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  // A count of one means this is the last idle cycle of the gap
  assign expired_o = (count_q <= WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/soundweb_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : soundweb_tx_serializer
// Description : Captures a framed encoder packet on start and streams it one
//               byte per valid/ready handshake, stopping after the ETX byte.
//               Define SOUNDWEB_TX_GAP_EN to insert GAP_CYCLES idle cycles
//               between consecutive bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module soundweb_tx_serializer
  import soundweb_pkg::*;
#(
  parameter int         PACKET_BYTES = SW_PACKET_BYTES,
  parameter logic [7:0] STX_BYTE     = SW_STX,
  parameter logic [7:0] ETX_BYTE     = SW_ETX,
  parameter int         GAP_CYCLES   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [8*PACKET_BYTES-1:0] packet,
  output logic [7:0]                tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [4:0]                byte_count
);

  localparam int IDX_W = (PACKET_BYTES > 1) ? $clog2(PACKET_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACKET_BYTES - 1);

  sw_state_e        state_q, state_d;
  logic [7:0]       buf_q [PACKET_BYTES];
  logic [IDX_W-1:0] index_q, index_d;
  logic [4:0]       count_q, count_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             capture;
  logic [7:0]       cur_byte;
  logic             is_etx;
  logic             last_slot;
  logic             stx_bad;

  // A start is honoured only in IDLE and not in the cycle a done/err pulse shows
  assign capture   = (state_q == ST_IDLE) && start && !done_q && !err_q;
  assign cur_byte  = buf_q[index_q];
  // Slot 0 is always STX, so only later slots can terminate the frame
  assign is_etx    = (index_q != '0) && (cur_byte == ETX_BYTE);
  assign last_slot = (index_q == LAST_IDX);
  assign stx_bad   = (buf_q[0] != STX_BYTE);

`ifdef SOUNDWEB_TX_GAP_EN
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  logic gap_load;
  logic gap_expired;

  soundweb_gap_timer #(
    .WIDTH(GAP_W)
  ) u_gap_timer (
    .clk       (clk),
    .reset     (reset),
    .load_i    (gap_load),
    .load_val_i(GAP_W'(GAP_CYCLES)),
    .expired_o (gap_expired)
  );
`endif

  // Next-state and datapath update for the transmit sequencer
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    count_d = count_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef SOUNDWEB_TX_GAP_EN
    gap_load = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (capture) begin
          state_d = ST_CHECK;
          index_d = '0;
          count_d = '0;
        end
      end
      ST_CHECK: begin
        state_d = stx_bad ? ST_IDLE : ST_SEND;
      end
      ST_SEND: begin
        if (tx_ready) begin
          count_d = count_q + 5'd1;
          if (is_etx) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (last_slot) begin
            // Every slot used without a terminator: framing fault
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end else begin
            index_d = index_q + 1'b1;
`ifdef SOUNDWEB_TX_GAP_EN
            if (GAP_CYCLES > 0) begin
              state_d  = ST_GAP;
              gap_load = 1'b1;
            end
`endif
          end
        end
      end
`ifdef SOUNDWEB_TX_GAP_EN
      ST_GAP: begin
        if (gap_expired) begin
          state_d = ST_SEND;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Index, accepted-byte counter and completion pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      index_q <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      index_q <= index_d;
      count_q <= count_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Capture buffer, loaded only by an accepted start so a busy packet is safe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PACKET_BYTES; i++) begin
        buf_q[i] <= 8'h00;
      end
    end else if (capture) begin
      for (int i = 0; i < PACKET_BYTES; i++) begin
        buf_q[i] <= packet[8*i +: 8];
      end
    end
  end

  // tx_valid derives from state alone, so reset drops it immediately
  assign tx_valid   = (state_q == ST_SEND);
  assign tx_data    = tx_valid ? cur_byte : 8'h00;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  // A bad STX is flagged during the CHECK cycle itself
  assign err        = err_q | ((state_q == ST_CHECK) && stx_bad);
  assign byte_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_soundweb_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_soundweb_tx_serializer
// Description : Directed self-checking bench for soundweb_tx_serializer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_soundweb_tx_serializer;

  localparam int PB = 29;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [8*PB-1:0] packet;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            tx_ready;
  logic            busy;
  logic            done;
  logic            err;
  logic [4:0]      byte_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp6 [6] = '{8'h02, 8'h8D, 8'h1B, 8'h83, 8'h00, 8'h03};

  logic [7:0] got [$];
  int         first_valid_k;
  int         done_k;
  int         err_k;
  int         done_pulses;
  int         err_pulses;
  int         hold_errs;
  int         end_count;
  logic       saw_valid;
  logic       timeout;

  soundweb_tx_serializer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .packet    (packet),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pkt6();
    packet = '0;
    packet[7:0]   = 8'h02;
    packet[15:8]  = 8'h8D;
    packet[23:16] = 8'h1B;
    packet[31:24] = 8'h83;
    packet[39:32] = 8'h00;
    packet[47:40] = 8'h03;
  endtask

  // Pulse start, then observe one cycle per step k (k=1 is the cycle after
  // the start cycle). mode 0: ready always high; mode 1: ready 1,0,0,1 repeating.
  task automatic run_stream(input int mode, input int restart_k, input int budget);
    logic       stall;
    logic [7:0] held;
    stall = 1'b0;
    held  = 8'h00;
    got.delete();
    first_valid_k = -1;
    done_k        = -1;
    err_k         = -1;
    done_pulses   = 0;
    err_pulses    = 0;
    hold_errs     = 0;
    end_count     = -1;
    saw_valid     = 1'b0;
    timeout       = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      start = (k == restart_k);
      if (k == restart_k) packet = {PB{8'hA5}};
      if (mode == 0) tx_ready = 1'b1;
      else tx_ready = (((k - 1) % 4) == 0) || (((k - 1) % 4) == 3);
      if (stall && (!tx_valid || (tx_data !== held))) hold_errs++;
      if (tx_valid) begin
        saw_valid = 1'b1;
        if (first_valid_k < 0) first_valid_k = k;
      end
      if (done) begin
        done_pulses++;
        if (done_k < 0) done_k = k;
      end
      if (err) begin
        err_pulses++;
        if (err_k < 0) err_k = k;
      end
      if (tx_valid && tx_ready) got.push_back(tx_data);
      stall = tx_valid && !tx_ready;
      held  = tx_data;
      if (done || err) begin
        end_count = int'(byte_count);
        timeout   = 1'b0;
        break;
      end
      tick();
    end
    start    = 1'b0;
    tx_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
    n_cmp++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL reset_done_err: got %b%b expected 00", done, err); end
    n_cmp++; if (byte_count !== 5'd0) begin n_bad++; $display("FAIL reset_byte_count: got %0d expected 0", byte_count); end
    #2 reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    load_pkt6();
    run_stream(0, -1, 40);
    n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL basic_timeout: got %b expected 0", timeout); end
    n_cmp++; if (got.size() != 6) begin n_bad++; $display("FAIL basic_len: got %0d expected 6", got.size()); end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      n_cmp++; if (got[i] !== exp6[i]) begin n_bad++; $display("FAIL basic_byte%0d: got %h expected %h", i, got[i], exp6[i]); end
    end
    n_cmp++; if (first_valid_k != 2) begin n_bad++; $display("FAIL basic_latency: got %0d expected 2", first_valid_k); end
    n_cmp++; if (done_k != 8) begin n_bad++; $display("FAIL basic_done_cycle: got %0d expected 8", done_k); end
    n_cmp++; if (end_count != 6) begin n_bad++; $display("FAIL basic_byte_count: got %0d expected 6", end_count); end
    n_cmp++; if (err_pulses != 0) begin n_bad++; $display("FAIL basic_err: got %0d expected 0", err_pulses); end
    n_cmp++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin n_bad++; $display("FAIL basic_idle_at_done: got busy=%b valid=%b expected 0 0", busy, tx_valid); end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL basic_done_pulse_width: got %b expected 0", done); end
    n_cmp++; if (byte_count !== 5'd6) begin n_bad++; $display("FAIL basic_count_hold: got %0d expected 6", byte_count); end
  endtask

  task automatic test_stall();
    load_pkt6();
    run_stream(1, -1, 60);
    n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL stall_timeout: got %b expected 0", timeout); end
    n_cmp++; if (hold_errs != 0) begin n_bad++; $display("FAIL stall_hold: got %0d violations expected 0", hold_errs); end
    n_cmp++; if (got.size() != 6) begin n_bad++; $display("FAIL stall_len: got %0d expected 6", got.size()); end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      n_cmp++; if (got[i] !== exp6[i]) begin n_bad++; $display("FAIL stall_byte%0d: got %h expected %h", i, got[i], exp6[i]); end
    end
    n_cmp++; if (done_k != 14) begin n_bad++; $display("FAIL stall_done_cycle: got %0d expected 14", done_k); end
    n_cmp++; if (end_count != 6) begin n_bad++; $display("FAIL stall_byte_count: got %0d expected 6", end_count); end
    tick();
  endtask

  task automatic test_bad_stx();
    load_pkt6();
    packet[7:0] = 8'h8D;
    run_stream(0, -1, 20);
    n_cmp++; if (err_k != 1) begin n_bad++; $display("FAIL badstx_err_cycle: got %0d expected 1", err_k); end
    n_cmp++; if (saw_valid !== 1'b0) begin n_bad++; $display("FAIL badstx_valid: got %b expected 0", saw_valid); end
    n_cmp++; if (done_pulses != 0) begin n_bad++; $display("FAIL badstx_done: got %0d expected 0", done_pulses); end
    tick();
    n_cmp++; if (busy !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL badstx_after: got busy=%b err=%b expected 0 0", busy, err); end
    n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL badstx_valid_after: got %b expected 0", tx_valid); end
  endtask

  task automatic test_no_etx();
    packet = {{28{8'h11}}, 8'h02};
    run_stream(0, -1, 60);
    n_cmp++; if (err_k != 31) begin n_bad++; $display("FAIL noetx_err_cycle: got %0d expected 31", err_k); end
    n_cmp++; if (got.size() != 29) begin n_bad++; $display("FAIL noetx_len: got %0d expected 29", got.size()); end
    n_cmp++; if (end_count != 29) begin n_bad++; $display("FAIL noetx_byte_count: got %0d expected 29", end_count); end
    n_cmp++; if (done_pulses != 0) begin n_bad++; $display("FAIL noetx_done: got %0d expected 0", done_pulses); end
    if (got.size() == 29) begin
      n_cmp++; if (got[0] !== 8'h02) begin n_bad++; $display("FAIL noetx_first: got %h expected 02", got[0]); end
      n_cmp++; if (got[28] !== 8'h11) begin n_bad++; $display("FAIL noetx_last: got %h expected 11", got[28]); end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    load_pkt6();
    run_stream(0, 4, 40);
    n_cmp++; if (got.size() != 6) begin n_bad++; $display("FAIL restart_len: got %0d expected 6", got.size()); end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      n_cmp++; if (got[i] !== exp6[i]) begin n_bad++; $display("FAIL restart_byte%0d: got %h expected %h", i, got[i], exp6[i]); end
    end
    n_cmp++; if (done_k != 8) begin n_bad++; $display("FAIL restart_done_cycle: got %0d expected 8", done_k); end
    // start coinciding with the done pulse must be ignored
    load_pkt6();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL start_on_done_busy: got %b expected 0", busy); end
    tick();
    n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL start_on_done_valid: got %b expected 0", tx_valid); end
    run_stream(0, -1, 40);
    n_cmp++; if (got.size() != 6 || done_k != 8) begin n_bad++; $display("FAIL second_packet: got len=%0d done=%0d expected 6 8", got.size(), done_k); end
    tick();
  endtask

  task automatic test_reset_mid();
    load_pkt6();
    tx_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 8'h1B) begin n_bad++; $display("FAIL mid_pre_reset: got valid=%b data=%h expected 1 1b", tx_valid, tx_data); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin n_bad++; $display("FAIL mid_reset_tx: got valid=%b data=%h expected 0 00", tx_valid, tx_data); end
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL mid_reset_flags: got %b%b%b expected 000", busy, done, err); end
    n_cmp++; if (byte_count !== 5'd0) begin n_bad++; $display("FAIL mid_reset_count: got %0d expected 0", byte_count); end
    #2 reset = 1'b0;
    tick();
    run_stream(0, -1, 40);
    n_cmp++; if (got.size() != 6) begin n_bad++; $display("FAIL mid_restart_len: got %0d expected 6", got.size()); end
    if (got.size() == 6) begin
      n_cmp++; if (got[0] !== 8'h02 || got[5] !== 8'h03) begin n_bad++; $display("FAIL mid_restart_ends: got %h..%h expected 02..03", got[0], got[5]); end
    end
    n_cmp++; if (end_count != 6) begin n_bad++; $display("FAIL mid_restart_count: got %0d expected 6", end_count); end
    tick();
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    tx_ready = 1'b0;
    packet   = '0;
    test_reset();
    test_basic();
    test_stall();
    test_bad_stx();
    test_no_etx();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
